// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock sequencer with staggered per-domain reset release
// Optional lock-loss persistence filter: define PLL_SEQ_LOSS_FILTER_EN
`timescale 1ns/1ps
module pll_reset_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = 1000,
    parameter int STABLE_CYCLES  = 64,
    parameter int MAX_RETRY      = 3,
    parameter int NUM_DOMAINS    = 3,
    parameter int STAGGER_CYCLES = 8,
    parameter int LOSS_FILTER    = 4
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   restart_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   sys_ready,
    output logic                   fault,
    output logic [2:0]             seq_state,
    output logic [7:0]             loss_count
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t      state;
    logic        lk_meta;
    logic        lk;
    logic [31:0] timer;
    logic [7:0]  retry;
    logic        released;
    logic        lock_lost;

    generate
        if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || STAGGER_CYCLES < 1 ||
            NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || MAX_RETRY < 0 || LOSS_FILTER < 1) begin : g_bad_params
            $error("pll_reset_sequencer: parameter out of range");
        end
    endgenerate

    assign seq_state = state;
    assign released  = (state == S_RELEASE) || (state == S_RUN);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk      <= lk_meta;
        end
    end

`ifdef PLL_SEQ_LOSS_FILTER_EN
    logic [31:0] loss_filt;

    // Dropouts shorter than LOSS_FILTER cycles never reach the FSM.
    assign lock_lost = released && !lk && (loss_filt == 32'(LOSS_FILTER - 1));

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_filt <= '0;
        end else if (restart_req || lk || !released || lock_lost) begin
            loss_filt <= '0;
        end else begin
            loss_filt <= loss_filt + 32'd1;
        end
    end
`else
    assign lock_lost = released && !lk;
`endif

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_PLL_RST;
            pll_rst    <= 1'b1;
            dom_rst_n  <= '0;
            sys_ready  <= 1'b0;
            fault      <= 1'b0;
            loss_count <= '0;
            retry      <= '0;
            timer      <= '0;
        end else if (restart_req) begin
            state     <= S_PLL_RST;
            pll_rst   <= 1'b1;
            dom_rst_n <= '0;
            sys_ready <= 1'b0;
            fault     <= 1'b0;
            retry     <= '0;
            timer     <= '0;
        end else if (lock_lost) begin
            state     <= S_PLL_RST;
            pll_rst   <= 1'b1;
            dom_rst_n <= '0;
            sys_ready <= 1'b0;
            timer     <= '0;
            if (loss_count != 8'hFF) begin
                loss_count <= loss_count + 8'd1;
            end
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (timer == 32'(RST_CYCLES - 1)) begin
                        state   <= S_WAIT_LOCK;
                        pll_rst <= 1'b0;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk) begin
                        state <= S_STABLE;
                        timer <= '0;
                    end else if (timer == 32'(LOCK_TIMEOUT - 1)) begin
                        timer   <= '0;
                        pll_rst <= 1'b1;
                        retry   <= retry + 8'd1;
                        if (retry >= 8'(MAX_RETRY)) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= S_PLL_RST;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_STABLE: begin
                    if (!lk) begin
                        state <= S_WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == 32'(STABLE_CYCLES - 1)) begin
                        state        <= S_RELEASE;
                        timer        <= '0;
                        retry        <= '0;
                        dom_rst_n[0] <= 1'b1;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_RELEASE: begin
                    // timer counts cycles since RELEASE entry; domain i opens at i*STAGGER_CYCLES.
                    if (timer == 32'((NUM_DOMAINS - 1) * STAGGER_CYCLES)) begin
                        state     <= S_RUN;
                        sys_ready <= 1'b1;
                    end else begin
                        timer <= timer + 32'd1;
                        for (int i = 1; i < NUM_DOMAINS; i++) begin
                            if (timer + 32'd1 == 32'(i * STAGGER_CYCLES)) begin
                                dom_rst_n[i] <= 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    dom_rst_n <= '1;
                    sys_ready <= 1'b1;
                end
                S_FAULT: begin
                    pll_rst   <= 1'b1;
                    dom_rst_n <= '0;
                    fault     <= 1'b1;
                end
                default: begin
                    state   <= S_PLL_RST;
                    pll_rst <= 1'b1;
                    timer   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - table-driven and directed bench for pll_reset_sequencer
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst;
    logic [2:0] dom_rst_n;
    logic       sys_ready;
    logic       fault;
    logic [2:0] seq_state;
    logic [7:0] loss_count;

    int n_checks = 0;
    int n_fail = 0;

    pll_reset_sequencer dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .dom_rst_n   (dom_rst_n),
        .sys_ready   (sys_ready),
        .fault       (fault),
        .seq_state   (seq_state),
        .loss_count  (loss_count)
    );

    always #10 refclk = ~refclk;

    typedef struct {
        logic       locked;
        logic       restart;
        int         cycles;
        logic [2:0] st;
        logic       prst;
        logic [2:0] dom;
        logic       rdy;
        logic       flt;
        logic [7:0] loss;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] st, input logic prst,
                             input logic [2:0] dom, input logic rdy, input logic flt, input logic [7:0] loss);
        check({name, "_state"}, 32'(seq_state), 32'(st));
        check({name, "_pll_rst"}, 32'(pll_rst), 32'(prst));
        check({name, "_dom_rst_n"}, 32'(dom_rst_n), 32'(dom));
        check({name, "_sys_ready"}, 32'(sys_ready), 32'(rdy));
        check({name, "_fault"}, 32'(fault), 32'(flt));
        check({name, "_loss_count"}, 32'(loss_count), 32'(loss));
    endtask

    task automatic do_reset(input logic locked);
        pll_locked  = locked;
        restart_req = 1'b0;
        rst_n       = 1'b0;
        tick(3);
        check_all("reset", 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int k = 0;
        while (seq_state !== s && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(seq_state), 32'(s));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Power-up with lock tied high, then a 2-cycle lock dropout in RUN.
        vecs[0]  = '{1'b1, 1'b0, 15, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1,  3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1,  3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 63, 3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1,  3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 1'b0, 7,  3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1,  3'd3, 1'b0, 3'b011, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 8,  3'd3, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{1'b1, 1'b0, 1,  3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 8'd0};
        vecs[9]  = '{1'b1, 1'b0, 5,  3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 8'd0};
        vecs[10] = '{1'b0, 1'b0, 2,  3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 8'd0};
`ifdef PLL_SEQ_LOSS_FILTER_EN
        vecs[11] = '{1'b1, 1'b0, 1,  3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 8'd0};
        vecs[12] = '{1'b1, 1'b0, 3,  3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 8'd0};
`else
        vecs[11] = '{1'b1, 1'b0, 1,  3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 1'b0, 3,  3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd1};
`endif

        do_reset(1'b1);
        for (int i = 0; i < 13; i++) begin
            pll_locked  = vecs[i].locked;
            restart_req = vecs[i].restart;
            tick(vecs[i].cycles);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].prst, vecs[i].dom,
                      vecs[i].rdy, vecs[i].flt, vecs[i].loss);
        end

        // Six-cycle dropout in RUN counts as one loss in both builds.
        do_reset(1'b1);
        wait_state(3'd4, 300, "loss6_reach_run");
        pll_locked = 1'b0;
        tick(6);
        pll_locked = 1'b1;
        tick(4);
        check_all("loss6", 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd1);

        // restart_req coincident with a lock loss in RUN wins and the loss is not counted.
        do_reset(1'b1);
        wait_state(3'd4, 300, "restart_loss_reach_run");
        pll_locked = 1'b0;
        tick(2);
        restart_req = 1'b1;
        tick(1);
        check_all("restart_loss", 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        restart_req = 1'b0;
        pll_locked  = 1'b1;
        tick(5);
        check("restart_loss_later_count", 32'(loss_count), 32'd0);

        // One-cycle lock dropout in STABLE at count 40 restarts the stability count.
        do_reset(1'b1);
        tick(55);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        check("stable_drop_still_stable", 32'(seq_state), 32'd2);
        tick(1);
        check("stable_drop_wait_lock", 32'(seq_state), 32'd1);
        tick(1);
        check("stable_drop_restable", 32'(seq_state), 32'd2);
        tick(63);
        check("stable_drop_count_63", 32'(seq_state), 32'd2);
        tick(1);
        check_all("stable_drop_release", 3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 8'd0);

        // No lock ever: four attempts of 16+1000 cycles, then FAULT.
        do_reset(1'b0);
        tick(1015);
        check_all("timeout1_wait", 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        tick(1);
        check_all("timeout1_retry", 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        tick(3047);
        check_all("timeout4_wait", 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        tick(1);
        check_all("fault_entry", 3'd5, 1'b1, 3'b000, 1'b0, 1'b1, 8'd0);
        pll_locked = 1'b1;
        tick(20);
        check_all("fault_hold", 3'd5, 1'b1, 3'b000, 1'b0, 1'b1, 8'd0);
        restart_req = 1'b1;
        tick(1);
        check_all("fault_restart", 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        restart_req = 1'b0;
        wait_state(3'd4, 300, "fault_restart_reach_run");
        check_all("fault_restart_run", 3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 8'd0);

        // 300 lock losses, each forced at the start of RELEASE.
        do_reset(1'b1);
        for (int i = 0; i < 300; i++) begin
            wait_state(3'd3, 200, $sformatf("sat%0d_reach_release", i));
            pll_locked = 1'b0;
            tick(6);
            pll_locked = 1'b1;
            if (i == 0) check("sat_first_loss", 32'(loss_count), 32'd1);
            if (i == 254) check("sat_reach_255", 32'(loss_count), 32'd255);
        end
        check("sat_after_300", 32'(loss_count), 32'd255);

        // Asynchronous reset in the middle of RELEASE.
        wait_state(3'd3, 200, "midrel_reach_release");
        tick(9);
        check("midrel_dom_before", 32'(dom_rst_n), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midrel_async_reset", 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        tick(2);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
